// File: rtl/b14_bus_responder.sv
// Closed-loop memory/bus slave for the b14 core: latency-accurate reads, writes,
// preload port, transaction trace FIFO, saturating counters and sticky error flags.
module b14_bus_responder #(
    parameter int AW          = 8,
    parameter int RD_LAT      = 2,
    parameter int TRACE_DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [19:0]   addr,
    input  logic [30:0]   datao,
    input  logic          rd,
    input  logic          wr,
    output logic [30:0]   datai,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [30:0]   ld_data,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [52:0]   trace_data,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count,
    output logic          oob_err,
    output logic          conflict,
    output logic          trace_ovf
);

    localparam int          PW       = $clog2(TRACE_DEPTH) + 1;
    localparam logic [30:0] OOB_DATA = 31'h7FFF_FFFF;

    logic [30:0]   mem [2**AW];
    logic          oob;
    logic [AW-1:0] word;
    logic [30:0]   rd_value;

    assign oob      = |addr[19:AW];
    assign word     = addr[AW-1:0];
    // Sampled before this edge's write lands, so rd+wr to one word returns the old data.
    assign rd_value = oob ? OOB_DATA : mem[word];

    // NOTE: memory arrays carry no reset; contents must survive reset and a reset
    // branch would turn the RAM into a wide bank of resettable flops.
    always_ff @(posedge clock) begin
        if (wr && !oob) mem[word] <= datao;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    logic [RD_LAT-1:0] pipe_vld;
    logic [30:0]       pipe_data [RD_LAT];

    // NOTE: sequential state uses non-blocking assignments so every stage shifts
    // from the values held before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
            datai <= '0;
        end else begin
            pipe_vld[0]  <= rd;
            pipe_data[0] <= rd_value;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
            if (pipe_vld[RD_LAT-1]) datai <= pipe_data[RD_LAT-1];
        end
    end

    logic [52:0]   fifo [TRACE_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, push, pop, push_ok;
    logic [52:0]   entry;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign push    = rd | wr;
    assign pop     = !empty && trace_ready;
    assign push_ok = push && (!full || pop);
    assign entry   = {wr, rd, addr, wr ? datao : 31'd0};

    assign trace_valid = !empty;
    assign trace_data  = empty ? '0 : fifo[rd_ptr[PW-2:0]];

    always_ff @(posedge clock) begin
        if (push_ok) fifo[wr_ptr[PW-2:0]] <= entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            oob_err   <= 1'b0;
            conflict  <= 1'b0;
            trace_ovf <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (push && oob)         oob_err   <= 1'b1;
            if (rd && wr)            conflict  <= 1'b1;
            if (push && full && !pop) trace_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_b14_bus_responder.sv
// Randomized and directed bench for b14_bus_responder against a queue-based
// transaction model (memory array, pending-read queue, trace queue).
module tb_b14_bus_responder;

    localparam int AW = 8, RD_LAT = 2, TD = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [19:0]   addr;
    logic [30:0]   datao;
    logic          rd, wr;
    logic [30:0]   datai;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [30:0]   ld_data;
    logic          trace_valid, trace_ready;
    logic [52:0]   trace_data;
    logic [15:0]   rd_count, wr_count;
    logic          oob_err, conflict, trace_ovf;

    b14_bus_responder #(.AW(AW), .RD_LAT(RD_LAT), .TRACE_DEPTH(TD)) dut (
        .clock(clock), .reset(reset), .addr(addr), .datao(datao), .rd(rd), .wr(wr),
        .datai(datai), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
        .rd_count(rd_count), .wr_count(wr_count), .oob_err(oob_err),
        .conflict(conflict), .trace_ovf(trace_ovf)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: transaction-level view of the responder.
    typedef struct { int due; logic [30:0] val; } rd_t;
    logic [30:0] mem_m [256];
    rd_t         pend [$];
    logic [52:0] tq [$];
    int          cyc = 0;
    logic [30:0] datai_m;
    int          rdc_m, wrc_m;
    bit          oob_m, conf_m, ovf_m;

    task automatic model_reset();
        pend.delete();
        tq.delete();
        datai_m = '0;
        rdc_m = 0; wrc_m = 0;
        oob_m = 0; conf_m = 0; ovf_m = 0;
    endtask

    task automatic model_edge();
        logic [30:0] rv;
        bit          is_oob;
        cyc++;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            datai_m = pend[0].val;
            void'(pend.pop_front());
        end
        is_oob = (addr >> AW) != 0;
        rv = is_oob ? 31'h7FFFFFFF : mem_m[addr[AW-1:0]];
        if (rd) pend.push_back('{due: cyc + RD_LAT, val: rv});
        if (tq.size() > 0 && trace_ready) void'(tq.pop_front());
        if (rd || wr) begin
            if (tq.size() < TD) tq.push_back({wr, rd, addr, wr ? datao : 31'h0});
            else ovf_m = 1;
        end
        if (wr && !is_oob) mem_m[addr[AW-1:0]] = datao;
        if (ld_en) mem_m[ld_addr] = ld_data;
        if (rd && rdc_m < 65535) rdc_m++;
        if (wr && wrc_m < 65535) wrc_m++;
        if ((rd || wr) && is_oob) oob_m = 1;
        if (rd && wr) conf_m = 1;
    endtask

    task automatic check_all();
        check("datai", datai, datai_m);
        check("trace_valid", trace_valid, tq.size() != 0);
        check("trace_data", trace_data, tq.size() != 0 ? tq[0] : 53'h0);
        check("rd_count", rd_count, rdc_m);
        check("wr_count", wr_count, wrc_m);
        check("oob_err", oob_err, oob_m);
        check("conflict", conflict, conf_m);
        check("trace_ovf", trace_ovf, ovf_m);
    endtask

    task automatic drive(input bit r, input bit w, input logic [19:0] a, input logic [30:0] d);
        rd = r; wr = w; addr = a; datao = d;
    endtask

    task automatic idle();
        drive(0, 0, 20'h0, 31'h0);
        ld_en = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [30:0] d);
        idle();
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    // Asserts reset between edges and checks the asynchronous clear right away.
    task automatic do_reset();
        idle();
        reset = 1;
        #1;
        model_reset();
        check_all();
        check("rst_datai", datai, 31'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    logic [30:0] saved;

    initial begin
        reset = 1; trace_ready = 1; ld_addr = '0; ld_data = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        for (int i = 0; i < 256; i++) preload(AW'(i), 31'($urandom));

        // Preloaded read with RD_LAT latency.
        preload(AW'(5), 31'h1234567);
        do_reset();
        drive(1, 0, 20'h5, 31'h0);
        tick();
        check("t1_trace", trace_data, {1'b0, 1'b1, 20'h5, 31'h0});
        idle();
        tick();
        check("t1_not_yet", datai, 31'h0);
        tick();
        check("t1_datai", datai, 31'h1234567);
        check("t1_rdc", rd_count, 16'd1);

        // Write then read back.
        do_reset();
        drive(0, 1, 20'h3, 31'h55);
        tick();
        drive(1, 0, 20'h3, 31'h0);
        tick();
        idle();
        tick();
        tick();
        check("t2_datai", datai, 31'h55);
        check("t2_wrc", wr_count, 16'd1);
        check("t2_rdc", rd_count, 16'd1);

        // rd+wr same word: old data returned, new data stored.
        preload(AW'(7), 31'hA);
        do_reset();
        drive(1, 1, 20'h7, 31'hB);
        tick();
        check("t3_ops", trace_data[52:51], 2'b11);
        check("t3_conflict", conflict, 1'b1);
        idle();
        tick();
        tick();
        check("t3_old", datai, 31'hA);
        drive(1, 0, 20'h7, 31'h0);
        tick();
        idle();
        tick();
        tick();
        check("t3_new", datai, 31'hB);

        // Out-of-range read and dropped write.
        do_reset();
        drive(1, 0, 20'h100, 31'h0);
        tick();
        idle();
        tick();
        tick();
        check("t4_datai", datai, 31'h7FFFFFFF);
        check("t4_oob", oob_err, 1'b1);
        saved = mem_m[0];
        drive(0, 1, 20'h100, 31'h777);
        tick();
        drive(1, 0, 20'h0, 31'h0);
        tick();
        idle();
        tick();
        tick();
        check("t4_unchanged", datai, saved);

        // Trace overflow then drain in order.
        do_reset();
        trace_ready = 0;
        for (int i = 0; i < 9; i++) begin
            drive(0, 1, 20'(10 + i), 31'(i));
            tick();
        end
        check("t5_valid", trace_valid, 1'b1);
        check("t5_ovf", trace_ovf, 1'b1);
        idle();
        trace_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check("t5_order", trace_data, {1'b1, 1'b0, 20'(10 + i), 31'(i)});
            tick();
        end
        check("t5_empty", trace_valid, 1'b0);

        // Reset discards an in-flight read; memory survives.
        do_reset();
        drive(1, 0, 20'h5, 31'h0);
        tick();
        do_reset();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_late", datai, 31'h0);
        end
        drive(1, 0, 20'h5, 31'h0);
        tick();
        idle();
        tick();
        tick();
        check("t6_intact", datai, 31'h1234567);

        // Randomized traffic with collisions, overflow and periodic resets.
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? (20'($urandom) | 20'h100)
                                               : 20'($urandom_range(0, 15)),
                  31'($urandom));
            ld_en       = ($urandom_range(0, 7) == 0);
            ld_addr     = AW'($urandom_range(0, 15));
            ld_data     = 31'($urandom);
            trace_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        trace_ready = 1;
        repeat (TD + RD_LAT + 2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
